// File: rtl/program_loader_if.sv
// Byte-receive and program-memory write bundle between a loader and its host side.
// The loader takes the slave modport; the byte source / memory side takes master.
interface program_loader_if #(
  parameter int unsigned NBITS_O = 11,
  parameter int unsigned NBITS_D = 16
);
  logic               i_Start;
  logic [7:0]         i_RxData;
  logic               i_RxValid;
  logic               o_WrEnable;
  logic [NBITS_O-1:0] o_WrAddr;
  logic [NBITS_D-1:0] o_WrData;
  logic               o_Busy;
  logic               o_Done;
  logic               o_Full;
  logic [NBITS_O-1:0] o_Count;

  modport master (
    output i_Start, i_RxData, i_RxValid,
    input  o_WrEnable, o_WrAddr, o_WrData, o_Busy, o_Done, o_Full, o_Count
  );

  modport slave (
    input  i_Start, i_RxData, i_RxValid,
    output o_WrEnable, o_WrAddr, o_WrData, o_Busy, o_Done, o_Full, o_Count
  );
endinterface

// File: rtl/program_loader.sv
// Assembles received byte pairs (high byte first) into instructions and writes them
// to consecutive program memory cells until a halt word or the last cell is written.
module program_loader #(
  parameter int unsigned NBITS_O = 11,
  parameter int unsigned NBITS_D = 16,
  parameter int unsigned CELDAS  = 10
) (
  input  logic             i_clock,
  input  logic             i_reset,
  program_loader_if.slave  bus
);

  localparam int unsigned LAST_ADDR = CELDAS - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    WRITE = 3'd3,
    END   = 3'd4
  } state_t;

  state_t             r_state, w_state_next;
  logic [NBITS_O-1:0] r_addr, w_addr_next;
  logic [NBITS_O-1:0] r_count, w_count_next;
  logic [7:0]         r_byte_hi, w_byte_hi_next;
  logic               r_wr_en, w_wr_en_next;
  logic [NBITS_O-1:0] r_wr_addr, w_wr_addr_next;
  logic [NBITS_D-1:0] r_wr_data, w_wr_data_next;
  logic               r_done, w_done_next;
  logic               r_full, w_full_next;
  logic               r_busy, w_busy_next;

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_count   <= '0;
      r_byte_hi <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_count   <= w_count_next;
      r_byte_hi <= w_byte_hi_next;
      r_wr_en   <= w_wr_en_next;
      r_wr_addr <= w_wr_addr_next;
      r_wr_data <= w_wr_data_next;
      r_done    <= w_done_next;
      r_full    <= w_full_next;
      r_busy    <= w_busy_next;
    end
  end

  // Next state; the write strobe is launched on the low-byte edge so it lines up with WRITE
  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_count_next   = r_count;
    w_byte_hi_next = r_byte_hi;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;
    w_done_next    = r_done;
    w_full_next    = r_full;

    case (r_state)
      IDLE: begin
        if (bus.i_Start) begin
          w_state_next = HIGH;
          w_addr_next  = '0;
          w_count_next = '0;
          w_done_next  = 1'b0;
          w_full_next  = 1'b0;
        end
      end
      HIGH: begin
        if (bus.i_RxValid) begin
          w_byte_hi_next = bus.i_RxData;
          w_state_next   = LOW;
        end
      end
      LOW: begin
        if (bus.i_RxValid) begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = r_addr;
          w_wr_data_next = NBITS_D'({r_byte_hi, bus.i_RxData});
          w_state_next   = WRITE;
        end
      end
      WRITE: begin
        w_count_next = r_count + NBITS_O'(1);
        // Address saturates at the last cell
        if (r_addr != NBITS_O'(LAST_ADDR)) begin
          w_addr_next = r_addr + NBITS_O'(1);
        end
        if (r_wr_data == '0) begin
          w_state_next = END;
          w_done_next  = 1'b1;
        end else if (r_addr == NBITS_O'(LAST_ADDR)) begin
          w_state_next = END;
          w_full_next  = 1'b1;
        end else begin
          w_state_next = HIGH;
        end
      end
      END: begin
        if (!bus.i_Start) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_busy_next = (w_state_next == HIGH) || (w_state_next == LOW) ||
                  (w_state_next == WRITE);
  end

  assign bus.o_WrEnable = r_wr_en;
  assign bus.o_WrAddr   = r_wr_addr;
  assign bus.o_WrData   = r_wr_data;
  assign bus.o_Busy     = r_busy;
  assign bus.o_Done     = r_done;
  assign bus.o_Full     = r_full;
  assign bus.o_Count    = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random load sessions
// compared against a word-level model of the loading rules.
module tb_program_loader;

  localparam int unsigned NBITS_O = 11;
  localparam int unsigned NBITS_D = 16;
  localparam int unsigned CELDAS  = 10;

  typedef logic [NBITS_O+NBITS_D-1:0] wr_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wr_t        obs_q[$];
  logic [7:0] stim_q[$];

  program_loader_if #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D)) bus ();

  program_loader #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .CELDAS(CELDAS)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every write strobe seen by the memory side
  always @(negedge clk) begin
    if (bus.o_WrEnable === 1'b1) obs_q.push_back({bus.o_WrAddr, bus.o_WrData});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    bus.i_RxData  = b;
    bus.i_RxValid = 1'b1;
    @(posedge clk); #1;
    bus.i_RxValid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.o_Busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout: o_Busy=%0b after 50 cycles, want 0", name, bus.o_Busy);
    end
  endtask

  // Drives stim_q as one session and checks writes and status against the model
  task automatic run_session(input string name, input int gap_max);
    wr_t  exp_q[$];
    logic exp_done = 1'b0;
    logic exp_full = 1'b0;
    int   cnt = 0;
    logic [15:0] w;
    for (int i = 0; i + 1 < stim_q.size(); i += 2) begin
      if (exp_done || exp_full) break;
      w = {stim_q[i], stim_q[i+1]};
      exp_q.push_back({NBITS_O'(cnt), w});
      cnt++;
      if (w == 16'h0000) exp_done = 1'b1;
      else if (cnt == CELDAS) exp_full = 1'b1;
    end

    obs_q.delete();
    @(posedge clk); #1;
    bus.i_Start = 1'b1;
    foreach (stim_q[i]) send_byte(stim_q[i], $urandom_range(0, gap_max));
    wait_idle(name);

    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d writes want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr %0d data %h want addr %0d data %h", name, i,
                 obs_q[i][NBITS_O+NBITS_D-1:NBITS_D], obs_q[i][NBITS_D-1:0],
                 exp_q[i][NBITS_O+NBITS_D-1:NBITS_D], exp_q[i][NBITS_D-1:0]);
      end
    end
    checks++;
    if (bus.o_Done !== exp_done || bus.o_Full !== exp_full) begin
      errors++;
      $display("FAIL %s status: got done %0b full %0b want done %0b full %0b", name,
               bus.o_Done, bus.o_Full, exp_done, exp_full);
    end
    checks++;
    if (bus.o_Count !== NBITS_O'(cnt)) begin
      errors++;
      $display("FAIL %s o_Count: got %0d want %0d", name, bus.o_Count, cnt);
    end

    // Held start and stray bytes in END must not start anything
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_Busy !== 1'b0 || obs_q.size() !== exp_q.size() ||
        bus.o_Done !== exp_done || bus.o_Full !== exp_full) begin
      errors++;
      $display("FAIL %s end_hold: got busy %0b writes %0d done %0b full %0b want busy 0 writes %0d done %0b full %0b",
               name, bus.o_Busy, obs_q.size(), bus.o_Done, bus.o_Full, exp_q.size(), exp_done, exp_full);
    end
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.i_Start   = 1'b0;
    bus.i_RxData  = 8'h00;
    bus.i_RxValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.o_WrEnable, bus.o_Busy, bus.o_Done, bus.o_Full, bus.o_WrAddr, bus.o_WrData, bus.o_Count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr %0b busy %0b done %0b full %0b addr %0d data %h count %0d want all 0",
               bus.o_WrEnable, bus.o_Busy, bus.o_Done, bus.o_Full, bus.o_WrAddr, bus.o_WrData, bus.o_Count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_idle: o_Busy got %0b want 0", bus.o_Busy);
    end
  endtask

  task automatic test_normal;
    stim_q = '{8'h10, 8'h01, 8'h28, 8'h02, 8'h00, 8'h00};
    run_session("normal", 0);
  endtask

  task automatic test_full;
    stim_q.delete();
    for (int i = 1; i <= 11; i++) begin
      stim_q.push_back(8'h08);
      stim_q.push_back(8'(i));
    end
    run_session("full", 1);
  endtask

  task automatic test_zero_opcode;
    stim_q = '{8'h00, 8'h05, 8'h12, 8'h34, 8'h00, 8'h00};
    run_session("zero_opcode", 0);
  endtask

  task automatic test_ignored_idle;
    int cnt_before;
    cnt_before = int'(bus.o_Count);
    obs_q.delete();
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || bus.o_Busy !== 1'b0 || bus.o_Count !== NBITS_O'(cnt_before)) begin
      errors++;
      $display("FAIL idle_ignore: got writes %0d busy %0b count %0d want writes 0 busy 0 count %0d",
               obs_q.size(), bus.o_Busy, bus.o_Count, cnt_before);
    end
  endtask

  task automatic test_latency;
    obs_q.delete();
    @(posedge clk); #1;
    bus.i_Start = 1'b1;
    @(posedge clk); #1;
    bus.i_RxData  = 8'h12;
    bus.i_RxValid = 1'b1;
    @(posedge clk); #1;
    bus.i_RxData  = 8'h34;
    @(negedge clk);
    checks++;
    if (bus.o_WrEnable !== 1'b0) begin
      errors++;
      $display("FAIL latency_before: o_WrEnable got %0b want 0", bus.o_WrEnable);
    end
    @(posedge clk); #1;
    bus.i_RxValid = 1'b0;
    checks++;
    if (bus.o_WrEnable !== 1'b1 || bus.o_WrAddr !== 11'd0 || bus.o_WrData !== 16'h1234) begin
      errors++;
      $display("FAIL latency_early: got wr %0b addr %0d data %h want wr 1 addr 0 data 1234",
               bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData);
    end
    @(negedge clk);
    checks++;
    if (bus.o_WrEnable !== 1'b1 || bus.o_WrAddr !== 11'd0 || bus.o_WrData !== 16'h1234) begin
      errors++;
      $display("FAIL latency_late: got wr %0b addr %0d data %h want wr 1 addr 0 data 1234",
               bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData);
    end
    @(negedge clk);
    checks++;
    if (bus.o_WrEnable !== 1'b0 || bus.o_WrAddr !== 11'd0 || bus.o_WrData !== 16'h1234 || bus.o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL strobe_width: got wr %0b addr %0d data %h busy %0b want wr 0 addr 0 data 1234 busy 1",
               bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, bus.o_Busy);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_idle("latency");
    checks++;
    if (bus.o_Done !== 1'b1 || bus.o_Count !== 11'd2 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL latency_end: got done %0b count %0d writes %0d want done 1 count 2 writes 2",
               bus.o_Done, bus.o_Count, obs_q.size());
    end
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_midword;
    obs_q.delete();
    @(posedge clk); #1;
    bus.i_Start = 1'b1;
    send_byte(8'h18, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_WrEnable, bus.o_Busy, bus.o_Done, bus.o_Full, bus.o_WrAddr, bus.o_WrData, bus.o_Count} !== '0) begin
      errors++;
      $display("FAIL reset_midword_now: got wr %0b busy %0b done %0b full %0b addr %0d data %h count %0d want all 0",
               bus.o_WrEnable, bus.o_Busy, bus.o_Done, bus.o_Full, bus.o_WrAddr, bus.o_WrData, bus.o_Count);
    end
    bus.i_RxData  = 8'h77;
    bus.i_RxValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_RxValid = 1'b0;
    bus.i_Start   = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || bus.o_WrEnable !== 1'b0 || bus.o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midword_hold: got writes %0d wr %0b busy %0b want writes 0 wr 0 busy 0",
               obs_q.size(), bus.o_WrEnable, bus.o_Busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    stim_q = '{8'h00, 8'h00};
    run_session("after_reset", 0);
  endtask

  task automatic test_random;
    logic [15:0] w;
    int k;
    for (int s = 0; s < 8; s++) begin
      stim_q.delete();
      k = $urandom_range(1, 13);
      for (int i = 0; i < k; i++) begin
        if (k < CELDAS && i == k - 1) w = 16'h0000;
        else if ($urandom_range(0, 3) == 0) w = {8'h00, 8'($urandom_range(1, 255))};
        else w = 16'($urandom_range(1, 65535));
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[7:0]);
      end
      run_session($sformatf("random%0d", s), 3);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ignored_idle();
    test_normal();
    test_ignored_idle();
    test_full();
    test_zero_opcode();
    test_latency();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter NBITS_O, default 11, the program memory address width.
REQ-002 SHALL have parameter NBITS_D, default 16, the instruction width: opcode in bits [15:11], operand in bits [10:0].
REQ-003 SHALL have parameter CELDAS, default 10, the number of program memory cells.
REQ-004 SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_Start, input, 1 bit: level request to begin a load session.
REQ-007 SHALL have port i_RxData, input, 8 bits: received byte.
REQ-008 SHALL have port i_RxValid, input, 1 bit: one-cycle strobe qualifying i_RxData.
REQ-009 SHALL have port o_WrEnable, output, 1 bit: program memory write strobe.
REQ-010 SHALL have port o_WrAddr, output, NBITS_O bits: program memory write address.
REQ-011 SHALL have port o_WrData, output, NBITS_D bits: instruction to write.
REQ-012 SHALL have port o_Busy, output, 1 bit: high while a session is in progress.
REQ-013 SHALL have port o_Done, output, 1 bit: the session ended on a halt word.
REQ-014 SHALL have port o_Full, output, 1 bit: the session ended because all CELDAS cells were written with no halt word.
REQ-015 SHALL have port o_Count, output, NBITS_O bits: number of words written in the current or last session.

Function
REQ-016 SHALL implement FSM states IDLE, HIGH, LOW, WRITE, END.
REQ-017 IDLE: SHALL go to HIGH when i_Start=1, clearing the address counter, o_Count, o_Done and o_Full.
REQ-018 HIGH: on i_RxValid=1, SHALL latch i_RxData into instruction bits [15:8] and go to LOW.
REQ-019 LOW: on i_RxValid=1, SHALL latch i_RxData into instruction bits [7:0] and go to WRITE.
REQ-020 Bytes per word: high byte first; no timeout; HIGH and LOW wait indefinitely.
REQ-021 WRITE: SHALL assert o_WrEnable for exactly one cycle, with o_WrAddr = the current address and o_WrData = the assembled word.
REQ-022 Write latency: o_WrEnable SHALL be high in the first cycle after the clock edge that sampled the low-byte strobe.
REQ-023 After WRITE, the address and o_Count SHALL each increment by 1.
REQ-024 After WRITE with a halt word (16'h0000): SHALL go to END with o_Done=1.
REQ-025 After WRITE with a non-halt word and the address equal to CELDAS-1: SHALL go to END with o_Full=1; the address SHALL never exceed CELDAS-1.
REQ-026 After WRITE in all other cases: SHALL go to HIGH.
REQ-027 END: o_Done and o_Full SHALL hold their values.
REQ-028 END: SHALL return to IDLE only when i_Start=0, so a held i_Start cannot trigger a second session.
REQ-029 o_Busy SHALL be 1 in HIGH, LOW and WRITE, and 0 in IDLE and END.
REQ-030 i_RxValid SHALL be ignored in IDLE, WRITE and END.
REQ-031 i_Start SHALL be ignored in HIGH, LOW and WRITE.
REQ-032 o_WrEnable SHALL be 0 in every state except WRITE.
REQ-033 o_WrData and o_WrAddr SHALL hold their last values outside WRITE.
REQ-034 Halt detection SHALL compare the full 16-bit word against 0; other words with opcode 5'b00000 and a nonzero operand are not halt.

Reset
REQ-035 While i_reset=0, the FSM SHALL be in IDLE.
REQ-036 While i_reset=0, o_WrEnable, o_Busy, o_Done, o_Full, o_WrAddr, o_WrData, o_Count and the latched byte SHALL all be 0.
REQ-037 Reset asserted in any state (including mid-word in LOW, or in WRITE) SHALL take effect immediately without completing a pending write.
REQ-038 After reset release, the block SHALL wait in IDLE for i_Start.

Verification
REQ-039 Normal load:
- Stimulus: i_Start=1, then bytes 10,01,28,02,00,00.
- Required: writes (addr 0, 0x1001), (addr 1, 0x2802), (addr 2, 0x0000); o_Done=1, o_Full=0, o_Count=3, o_Busy=0.
REQ-040 Full load:
- Stimulus: 10 non-halt words 0x0801..0x080A.
- Required: addresses 0..9 written in order; o_Full=1, o_Done=0, o_Count=10; an 11th byte pair produces no write.
REQ-041 Reset mid-word:
- Stimulus: i_reset=0 asynchronously after byte 0x18, while in LOW.
- Required: immediately o_WrEnable=0 and all outputs 0; after release, i_Start plus 00,00 writes 0x0000 at addr 0.
REQ-042 Ignored inputs:
- Stimulus: i_RxValid pulses with 0xFF in IDLE and in END.
- Required: no o_WrEnable and no state change; i_Start held high in END gives no restart until it drops and rises again.
REQ-043 Latency and strobe width:
- Stimulus: low-byte strobe at cycle n.
- Required: o_WrEnable=1 only in cycle n+1; o_WrAddr/o_WrData stable in that cycle.
REQ-044 Non-halt zero opcode:
- Stimulus: word 0x0005.
- Required: written at the current address; the session continues in HIGH; o_Done=0.
